controle_buzzer: RTL
====================

Name: controle_buzzer

Overview:
- Scheduler in front of the buzzer tone generator. Drives the generator's count-enable and its one-hot note selector.
- Shares the buzzer between two requesters: the game FSM, which requests single timed notes, and the error/alarm path, which requests a fixed three-tone descending pattern.
- Owns all tone and pause timing, so requesters only issue one-cycle pulses and watch ocupado and fim_toque.

Parameters:
- DURACAO_NOTA, 500, clock cycles each tone is held (>=1)
- DURACAO_PAUSA, 100, silent cycles between tones of the error pattern (>=1)
- CW, 16, width of the internal cycle counter; must hold max(DURACAO_NOTA, DURACAO_PAUSA)-1

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- toca_nota  in  1  one-cycle request from game FSM to play nota
- nota  in  4  one-hot note: 0001=1/8, 0010=1/4, 0100=1/3, 1000=1/2 clock
- toca_erro  in  1  one-cycle request to play the error pattern
- buzzer_conta  out  1  enable to tone generator; 1 while a tone sounds
- buzzer_seletor  out  4  one-hot note to tone generator; 0000 when silent
- ocupado  out  1  high while a note, tone or pause is in progress
- fim_toque  out  1  one-cycle pulse when a note or the error pattern completes
- tocando_erro  out  1  high during the whole error pattern, pauses included

Behaviour:
- All outputs are registered. Reset is synchronous: on the edge where reset=1, state=INICIAL, counter=0 and every output=0. This applies mid-tone as well; no fim_toque is emitted on reset.
- States: INICIAL, TOCA_NOTA, ERRO_T0, ERRO_P0, ERRO_T1, ERRO_P1, ERRO_T2, FIM.
- Accepting requests: requests are sampled only in INICIAL or FIM.
  - toca_erro=1 -> ERRO_T0.
  - Otherwise, toca_nota=1 with nota exactly one-hot -> TOCA_NOTA, and nota is latched.
  - toca_nota with nota not one-hot (0000 or multi-bit) is ignored; state stays or goes to INICIAL.
  - toca_nota and toca_erro in the same cycle -> the error pattern wins and the note is dropped.
- Latency: a request sampled at edge k gives buzzer_conta=1 and ocupado=1 in the cycle after edge k.
- TOCA_NOTA:
  - buzzer_conta=1, buzzer_seletor=latched nota, held for exactly DURACAO_NOTA cycles.
  - Counter starts at 0 on entry; leave when counter==DURACAO_NOTA-1.
  - toca_nota while busy is ignored (no queueing).
  - toca_erro while busy preempts: next state ERRO_T0 and the counter clears. The aborted note gets no fim_toque.
- Error pattern:
  - ERRO_T0: seletor 1000. ERRO_T1: seletor 0100. ERRO_T2: seletor 0001. Each tone lasts DURACAO_NOTA cycles with conta=1.
  - ERRO_P0 and ERRO_P1 last DURACAO_PAUSA cycles each, with conta=0, seletor=0000, ocupado=1.
  - Total length is 3*DURACAO_NOTA + 2*DURACAO_PAUSA cycles.
  - toca_erro or toca_nota during the pattern is ignored; the pattern does not restart.
- FIM: lasts 1 cycle with fim_toque=1, ocupado=0, conta=0, seletor=0000. It accepts a new request exactly as INICIAL does, which gives back-to-back play with one silent cycle. With no request it goes to INICIAL.
- Invariants:
  - buzzer_seletor is 0000 whenever buzzer_conta=0, and exactly one-hot whenever buzzer_conta=1.
  - Counter width is CW. The counter never wraps within a state because it is cleared on every state change.

Decomposition:
- Package pkg_buzzer holds:
  - state encoding for controle_buzzer
  - note constants NOTA_OITAVO=0001, NOTA_QUARTO=0010, NOTA_TERCO=0100, NOTA_MEIO=1000
  - ERRO_SEQ, the ordered list 1000, 0100, 0001
- One sub-module is natural: temporizador_toque, a CW-bit counter with synchronous clear and enable, whose fim output compares against a limit input. The FSM selects DURACAO_NOTA-1 or DURACAO_PAUSA-1 as the limit.

Test Plan (DURACAO_NOTA=4, DURACAO_PAUSA=2):
1. Reset, then toca_nota=1 with nota=0010 at edge 0.
   -> Cycles 1-4: conta=1, seletor=0010, ocupado=1. Cycle 5: fim_toque=1, ocupado=0. Cycle 6: all outputs 0.
2. toca_erro pulse.
   -> Sequence 1000×4, silence×2, 0100×4, silence×2, 0001×4. Then fim_toque for 1 cycle. tocando_erro=1 for all 16 cycles.
3. toca_nota (nota=1000), then toca_erro on the 2nd tone cycle.
   -> Next cycle: seletor=1000 with tocando_erro=1 and the counter restarted. The full 16-cycle pattern plays and only one fim_toque pulse occurs.
4. toca_nota and toca_erro in the same cycle; also toca_nota with nota=0000 and with nota=0110.
   -> Simultaneous case plays the error pattern. Both invalid notes give ocupado=0 and conta=0.
5. toca_nota asserted again during FIM.
   -> The new note starts the next cycle, with exactly one silent cycle between the two notes. A toca_nota during a tone is ignored.
6. reset=1 on the 3rd cycle of ERRO_T1.
   -> Next cycle: all outputs 0 and no fim_toque. A subsequent toca_nota (nota=0001) plays normally.

Source files
------------

// File: rtl/controle_buzzer_pkg.sv
// rtl/controle_buzzer_pkg.sv - states, note constants and output decoding for the buzzer scheduler
package pkg_buzzer;

  typedef enum logic [2:0] {
    INICIAL,
    TOCA_NOTA,
    ERRO_T0,
    ERRO_P0,
    ERRO_T1,
    ERRO_P1,
    ERRO_T2,
    FIM
  } estado_t;

  localparam logic [3:0] NOTA_OITAVO = 4'b0001;
  localparam logic [3:0] NOTA_QUARTO = 4'b0010;
  localparam logic [3:0] NOTA_TERCO  = 4'b0100;
  localparam logic [3:0] NOTA_MEIO   = 4'b1000;
  localparam logic [3:0] NOTA_NENHUMA = 4'b0000;

  // Descending alarm: index 0 is the first tone played.
  localparam logic [3:0] ERRO_SEQ [3] = '{NOTA_MEIO, NOTA_TERCO, NOTA_OITAVO};

  typedef struct packed {
    logic       conta;
    logic [3:0] seletor;
    logic       ocupado;
    logic       fim;
    logic       erro;
  } saida_t;

  function automatic logic eh_one_hot(input logic [3:0] n);
    return (n != 4'b0000) && ((n & (n - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic eh_pausa(input estado_t e);
    return (e == ERRO_P0) || (e == ERRO_P1);
  endfunction

  function automatic logic eh_erro(input estado_t e);
    return (e == ERRO_T0) || (e == ERRO_P0) || (e == ERRO_T1) ||
           (e == ERRO_P1) || (e == ERRO_T2);
  endfunction

  // Outputs that belong to a state, so the FSM can load them on the entering edge.
  function automatic saida_t saida_de(input estado_t e, input logic [3:0] n);
    saida_t s;
    s = '0;
    case (e)
      TOCA_NOTA: begin
        s.conta   = 1'b1;
        s.seletor = n;
      end
      ERRO_T0: begin
        s.conta   = 1'b1;
        s.seletor = ERRO_SEQ[0];
      end
      ERRO_T1: begin
        s.conta   = 1'b1;
        s.seletor = ERRO_SEQ[1];
      end
      ERRO_T2: begin
        s.conta   = 1'b1;
        s.seletor = ERRO_SEQ[2];
      end
      default: begin
        s.conta   = 1'b0;
        s.seletor = NOTA_NENHUMA;
      end
    endcase
    s.ocupado = (e != INICIAL) && (e != FIM);
    s.fim     = (e == FIM);
    s.erro    = eh_erro(e);
    return s;
  endfunction

endpackage

// File: rtl/controle_buzzer_temporizador_toque.sv
// rtl/controle_buzzer_temporizador_toque.sv - cycle counter with clear/enable and limit compare
module temporizador_toque #(
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_limpa,
  input  logic          i_habilita,
  input  logic [CW-1:0] i_limite,
  output logic          o_fim
);

  logic [CW-1:0] r_cont;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_limpa) begin
      r_cont <= '0;
    end else if (i_habilita) begin
      r_cont <= r_cont + 1'b1;
    end
  end

  assign o_fim = (r_cont == i_limite);

endmodule

// File: rtl/controle_buzzer.sv
// rtl/controle_buzzer.sv - arbitrates the buzzer between single notes and the error pattern
module controle_buzzer
  import pkg_buzzer::*;
#(
  parameter int DURACAO_NOTA  = 500,
  parameter int DURACAO_PAUSA = 100,
  parameter int CW            = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       toca_nota,
  input  logic [3:0] nota,
  input  logic       toca_erro,
  output logic       buzzer_conta,
  output logic [3:0] buzzer_seletor,
  output logic       ocupado,
  output logic       fim_toque,
  output logic       tocando_erro
);

  localparam logic [CW-1:0] LIM_NOTA  = CW'(DURACAO_NOTA - 1);
  localparam logic [CW-1:0] LIM_PAUSA = CW'(DURACAO_PAUSA - 1);

  estado_t       r_estado;
  logic [3:0]    r_nota;
  saida_t        r_saida;

  logic          w_fim;
  logic          w_limpa;
  logic          w_habilita;
  logic [CW-1:0] w_limite;
  logic          w_nota_valida;

  assign w_nota_valida = toca_nota && eh_one_hot(nota);
  assign w_limite      = eh_pausa(r_estado) ? LIM_PAUSA : LIM_NOTA;
  assign w_habilita    = r_saida.ocupado;

  // Clearing on every state change keeps the counter at 0 on entry to each tone/pause.
  assign w_limpa = (r_estado == INICIAL) || (r_estado == FIM) || w_fim ||
                   ((r_estado == TOCA_NOTA) && toca_erro);

  temporizador_toque #(
    .CW(CW)
  ) u_temporizador (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_limpa    (w_limpa),
    .i_habilita (w_habilita),
    .i_limite   (w_limite),
    .o_fim      (w_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_nota   <= NOTA_NENHUMA;
      r_saida  <= '0;
    end else begin
      case (r_estado)
        INICIAL, FIM: begin
          if (toca_erro) begin
            r_estado <= ERRO_T0;
            r_saida  <= saida_de(ERRO_T0, r_nota);
          end else if (w_nota_valida) begin
            r_estado <= TOCA_NOTA;
            r_nota   <= nota;
            r_saida  <= saida_de(TOCA_NOTA, nota);
          end else begin
            r_estado <= INICIAL;
            r_saida  <= saida_de(INICIAL, r_nota);
          end
        end
        TOCA_NOTA: begin
          if (toca_erro) begin
            r_estado <= ERRO_T0;
            r_saida  <= saida_de(ERRO_T0, r_nota);
          end else if (w_fim) begin
            r_estado <= FIM;
            r_saida  <= saida_de(FIM, r_nota);
          end
        end
        ERRO_T0: begin
          if (w_fim) begin
            r_estado <= ERRO_P0;
            r_saida  <= saida_de(ERRO_P0, r_nota);
          end
        end
        ERRO_P0: begin
          if (w_fim) begin
            r_estado <= ERRO_T1;
            r_saida  <= saida_de(ERRO_T1, r_nota);
          end
        end
        ERRO_T1: begin
          if (w_fim) begin
            r_estado <= ERRO_P1;
            r_saida  <= saida_de(ERRO_P1, r_nota);
          end
        end
        ERRO_P1: begin
          if (w_fim) begin
            r_estado <= ERRO_T2;
            r_saida  <= saida_de(ERRO_T2, r_nota);
          end
        end
        ERRO_T2: begin
          if (w_fim) begin
            r_estado <= FIM;
            r_saida  <= saida_de(FIM, r_nota);
          end
        end
        default: begin
          r_estado <= INICIAL;
          r_saida  <= '0;
        end
      endcase
    end
  end

  assign buzzer_conta   = r_saida.conta;
  assign buzzer_seletor = r_saida.seletor;
  assign ocupado        = r_saida.ocupado;
  assign fim_toque      = r_saida.fim;
  assign tocando_erro   = r_saida.erro;

endmodule
